dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the RISC-V datapath's load/store path. It accepts one doubleword request at a time from the datapath (the initiator driving memread/memwrite, address and store data) and returns read data or a write acknowledgement after a fixed, parameterised access latency. It replaces the zero-latency combinational data memory so the pipeline can be exercised against realistic stalls, using a valid/ready handshake in each direction. Storage is an internal array of 64-bit words.

## Interface

**Parameters**
- `DEPTH`, default 256: number of 64-bit words; valid word index range is 0..DEPTH-1.
- `LATENCY`, default 2: number of cycles from request acceptance to `resp_valid`. Legal range 1..15; held in a 4-bit counter.

**Ports**
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: synchronous active-low reset, sampled on the rising edge of `clk`.
- `req_valid`, in, 1: the request fields are valid.
- `req_ready`, out, 1: the responder can accept a request.
- `req_write`, in, 1: 1 means store (memwrite), 0 means load (memread).
- `req_addr`, in, 64: byte address.
- `req_wdata`, in, 64: store data.
- `resp_valid`, out, 1: a response is present.
- `resp_ready`, in, 1: the initiator consumes the response.
- `resp_rdata`, out, 64: load data. It is 0 for stores and for errored requests.
- `resp_err`, out, 1: the request was misaligned or out of range.

## Operation

**States:** IDLE, WAIT, RESP.

**IDLE**
- `req_ready`=1.
- A request is accepted on an edge where `req_valid` and `req_ready` are both 1. On that edge the block:
  - captures `req_write`, `req_addr` and `req_wdata`;
  - computes err = (`req_addr[2:0]` != 0) or (`req_addr[63:3]` >= DEPTH);
  - loads cnt = LATENCY-1 and moves to WAIT.
- `req_*` values are sampled only at acceptance.

**WAIT**
- `req_ready`=0.
- If cnt != 0, cnt is decremented.
- If cnt == 0, on that edge the block performs the access and moves to RESP:
  - store, no err: `mem[addr[63:3]]` <= wdata.
  - load, no err: `resp_rdata` <= `mem[addr[63:3]]`.
  - any err: no memory write, `resp_rdata` <= 0, `resp_err` <= 1.
  - store, no err: `resp_rdata` <= 0, `resp_err` <= 0.

**RESP**
- `resp_valid`=1.
- `resp_rdata` and `resp_err` are held stable while `resp_ready`=0.
- On an edge with `resp_ready`=1: `resp_valid` <= 0, `resp_err` <= 0, `resp_rdata` <= 0, and the state moves to IDLE.

**Other rules**
- `req_valid` asserted outside IDLE is ignored. No request is queued.
- Only one request is ever outstanding.
- Memory contents are not cleared by reset.

## Timing

**Reset values** (on an edge with `rst_n`=0):
- state IDLE, cnt 0
- `req_ready` 1, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0
- All outputs are registered.

**Latency**
- With the acceptance edge as E0, the memory access occurs at edge E0+LATENCY.
- `resp_valid` is high in the cycle following E0+LATENCY.
- With `resp_ready` held at 1, the response handshake is at edge E0+LATENCY+1 and `req_ready` returns high after it.
- The next acceptance is at E0+LATENCY+2 at the earliest, giving a minimum request period of LATENCY+2 cycles.

**Boundary conditions**
- LATENCY=1: WAIT lasts exactly one cycle.
- Address equal to 8×(DEPTH-1) is legal. 8×DEPTH raises err.
- Address bits above the word index participate in the range check; there is no wrap-around.
- Reset asserted in WAIT before the access edge: the store is dropped and memory is unchanged.
- Reset asserted in RESP: the response is discarded.
- Reset has priority over every other event on the same edge.
- `resp_ready` held high while in IDLE or WAIT has no effect.

## Test plan

- **Store then load, LATENCY=2.** Store 0xDEAD_BEEF_0123_4567 to addr 0x40, then load 0x40.
  - Store response: `resp_valid` 2 cycles after acceptance, `resp_err`=0, `resp_rdata`=0.
  - Load response: `resp_rdata`=0xDEAD_BEEF_0123_4567.
- **Misaligned load.** Load addr 0x44 → `resp_err`=1, `resp_rdata`=0, memory unchanged.
- **Out-of-range store, DEPTH=256.** Store 0x1 to addr 0x800 → `resp_err`=1. A following load of 0x0 returns its previous value.
- **Backpressure.** Hold `resp_ready`=0 for 5 cycles after a load response → `resp_valid` and `resp_rdata` are stable and `req_ready`=0 throughout. Raise `resp_ready` → IDLE one cycle later.
- **Reset mid-WAIT, LATENCY=4.** Store 0xFF to 0x08, pull `rst_n` low 1 cycle after acceptance, then load 0x08 → the old value is returned, and all outputs are at reset values during reset.
- **Request while busy.** Keep `req_valid`=1 with a second address during WAIT/RESP → it is not accepted until IDLE, and the first response is unaffected.

Source files
------------

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with valid/ready handshakes on request and response.
// One doubleword request outstanding at a time; storage is a 64-bit word array.
module dmem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [60:0] DepthW  = 61'(DEPTH);
    localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [63:0]       wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              mem_we;

    logic [63:0] mem_q [DEPTH];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        err_d        = err_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        resp_err_d   = resp_err_q;
        mem_we       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready_q) begin
                    write_d     = req_write;
                    idx_d       = req_addr[IdxW+2:3];
                    wdata_d     = req_wdata;
                    // Full upper address is range-checked so high bits never alias low words.
                    err_d       = (req_addr[2:0] != 3'b000) || (req_addr[63:3] >= DepthW);
                    cnt_d       = CntInit;
                    req_ready_d = 1'b0;
                    state_d     = StWait;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d      = StResp;
                    resp_valid_d = 1'b1;
                    if (err_q) begin
                        rdata_d    = 64'd0;
                        resp_err_d = 1'b1;
                    end else if (write_q) begin
                        mem_we     = 1'b1;
                        rdata_d    = 64'd0;
                        resp_err_d = 1'b0;
                    end else begin
                        rdata_d    = mem_q[idx_q];
                        resp_err_d = 1'b0;
                    end
                end
            end
            StResp: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    rdata_d      = 64'd0;
                    req_ready_d  = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= 64'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= 64'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            err_q        <= err_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Memory is not reset; reset only blocks a pending store.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: vector table plus hand sequences for backpressure, busy and reset cases.
// Two instances (LATENCY 2 and 4) share stimulus; sel picks which one receives requests.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_write, resp_ready, sel;
    logic [63:0] req_addr, req_wdata;

    logic        rr2, rv2, re2, rr4, rv4, re4;
    logic [63:0] rd2, rd4;
    logic        m_req_ready, m_resp_valid, m_resp_err;
    logic [63:0] m_resp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        w;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
    } vec_t;
    vec_t vecs[14];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid & ~sel),
        .req_ready (rr2),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(rv2),
        .resp_ready(resp_ready),
        .resp_rdata(rd2),
        .resp_err  (re2)
    );

    dmem_responder #(.DEPTH(256), .LATENCY(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid & sel),
        .req_ready (rr4),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(rv4),
        .resp_ready(resp_ready),
        .resp_rdata(rd4),
        .resp_err  (re4)
    );

    assign m_req_ready  = sel ? rr4 : rr2;
    assign m_resp_valid = sel ? rv4 : rv2;
    assign m_resp_rdata = sel ? rd4 : rd2;
    assign m_resp_err   = sel ? re4 : re2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, "_req_ready"}, 64'(m_req_ready), 64'd1);
        chk({name, "_resp_valid"}, 64'(m_resp_valid), 64'd0);
        chk({name, "_resp_rdata"}, m_resp_rdata, 64'd0);
        chk({name, "_resp_err"}, 64'(m_resp_err), 64'd0);
    endtask

    // Returns just after the acceptance edge with the expectation queued.
    task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] d,
                         input logic [63:0] er, input logic ee);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!m_req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("req_ready_idle", 64'(m_req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e.rdata = er;
        e.err   = ee;
        sb.push_back(e);
    endtask

    // Called just after the acceptance edge; response must appear on negedge LATENCY+1.
    task automatic wait_resp(input string name);
        int   lat = sel ? 4 : 2;
        int   n   = 1;
        exp_t e;
        @(negedge clk);
        while (!m_resp_valid && n < 40) begin
            chk({name, "_busy_ready"}, 64'(m_req_ready), 64'd0);
            n++;
            @(negedge clk);
        end
        chk({name, "_latency"}, 64'(n), 64'(lat + 1));
        chk({name, "_resp_ready_low"}, 64'(m_req_ready), 64'd0);
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_scoreboard: got empty queue, expected one entry", name);
        end else begin
            e = sb.pop_front();
            chk({name, "_rdata"}, m_resp_rdata, e.rdata);
            chk({name, "_err"}, 64'(m_resp_err), 64'(e.err));
        end
    endtask

    task automatic finish_resp(input string name);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({name, "_valid_drop"}, 64'(m_resp_valid), 64'd0);
        chk({name, "_ready_back"}, 64'(m_req_ready), 64'd1);
    endtask

    task automatic collect(input string name);
        resp_ready = 1'b1;
        wait_resp(name);
        finish_resp(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 64'h0,               64'h5555_AAAA_1234_5678, 64'h0, 1'b0};
        vecs[1]  = '{1'b1, 64'h40,              64'hDEAD_BEEF_0123_4567, 64'h0, 1'b0};
        vecs[2]  = '{1'b0, 64'h40,              64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0};
        vecs[3]  = '{1'b0, 64'h44,              64'h0, 64'h0, 1'b1};
        vecs[4]  = '{1'b1, 64'h800,             64'h1, 64'h0, 1'b1};
        vecs[5]  = '{1'b0, 64'h0,               64'h0, 64'h5555_AAAA_1234_5678, 1'b0};
        vecs[6]  = '{1'b1, 64'h7F8,             64'h0F0F_0F0F_F0F0_F0F0, 64'h0, 1'b0};
        vecs[7]  = '{1'b0, 64'h7F8,             64'h0, 64'h0F0F_0F0F_F0F0_F0F0, 1'b0};
        vecs[8]  = '{1'b0, 64'h800,             64'h0, 64'h0, 1'b1};
        vecs[9]  = '{1'b1, 64'h0000_0100_0000_0040, 64'h1111, 64'h0, 1'b1};
        vecs[10] = '{1'b0, 64'h40,              64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0};
        vecs[11] = '{1'b1, 64'h43,              64'h2222, 64'h0, 1'b1};
        vecs[12] = '{1'b0, 64'h40,              64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0};
        vecs[13] = '{1'b0, 64'h7,               64'h0, 64'h0, 1'b1};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 64'h0;
        req_wdata  = 64'h0;
        resp_ready = 1'b0;
        sel        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("reset_l2");
        sel = 1'b1;
        #1;
        chk_reset_outs("reset_l4");
        sel   = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err);
            collect($sformatf("vec%0d", i));
        end

        // Backpressure: response must hold for 5 cycles with resp_ready low.
        resp_ready = 1'b0;
        issue(1'b0, 64'h40, 64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0);
        wait_resp("bp");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(m_resp_valid), 64'd1);
            chk("bp_hold_rdata", m_resp_rdata, 64'hDEAD_BEEF_0123_4567);
            chk("bp_hold_ready", 64'(m_req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        finish_resp("bp");

        // Request held during WAIT/RESP is taken only once back in IDLE.
        issue(1'b0, 64'h40, 64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 64'h7F8;
        wait_resp("busy_first");
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("busy_ready_back", 64'(m_req_ready), 64'd1);
        sb.push_back('{64'h0F0F_0F0F_F0F0_F0F0, 1'b0});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_resp("busy_second");
        finish_resp("busy_second");

        // Reset while a response is pending discards it.
        resp_ready = 1'b0;
        issue(1'b0, 64'h0, 64'h0, 64'h5555_AAAA_1234_5678, 1'b0);
        wait_resp("rst_resp");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_reset_outs("rst_resp_after");
        rst_n = 1'b1;

        // LATENCY=4: reset one cycle after accepting a store drops the store.
        sel = 1'b1;
        issue(1'b1, 64'h08, 64'hAA, 64'h0, 1'b0);
        collect("l4_store");
        issue(1'b1, 64'h08, 64'hFF, 64'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_reset_outs("rst_wait_a");
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_reset_outs("rst_wait_b");
        rst_n = 1'b1;
        sb.delete();
        repeat (6) @(posedge clk);
        #1;
        issue(1'b0, 64'h08, 64'h0, 64'hAA, 1'b0);
        collect("l4_load_old");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
